// File: rtl/half_pkg.sv
// rtl/half_pkg.sv - shared binary16 types, constants and helpers for the half_* blocks
package half_pkg;

    typedef logic [15:0] half_t;

    // Input FSM of the vector summer.
    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;

    localparam half_t HALF_POS_ZERO = 16'h0000;
    localparam half_t HALF_ONE      = 16'h3C00;

    // Widest keep mask popcount accepts; callers zero-extend into it.
    localparam int POP_MAX = 256;

    function automatic logic [15:0] popcount(input logic [POP_MAX-1:0] v);
        logic [15:0] n;
        n = '0;
        for (int i = 0; i < POP_MAX; i++) begin
            n = n + 16'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/delay.sv
// rtl/delay.sv - fixed-depth register delay line with asynchronous clear
// Ports: clk, rstn (async, active-low), d (WIDTH) in, q (WIDTH) out = d delayed DEPTH cycles.
module delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (DEPTH == 0) begin : g_wire
        assign q = d;
    end else begin : g_pipe
        logic [WIDTH-1:0] pipe [DEPTH];

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int i = 0; i < DEPTH; i++) begin
                    pipe[i] <= '0;
                end
            end else begin
                pipe[0] <= d;
                for (int i = 1; i < DEPTH; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end

        assign q = pipe[DEPTH-1];
    end

endmodule

// File: rtl/half_add.sv
// rtl/half_add.sv - binary16 adder, round-to-nearest-even, one output register
// Ports: clk, rstn (async, active-low), a/b binary16 operands, sum = a+b registered (latency 1).
module half_add
    import half_pkg::*;
(
    input  logic  clk,
    input  logic  rstn,
    input  half_t a,
    input  half_t b,
    output half_t sum
);

    logic        a_nan, b_nan, a_inf, b_inf;
    half_t       big, sml, res;
    logic [4:0]  eb, es, d;
    logic [13:0] xb, xs, mask, al, s;
    logic [14:0] s15;
    logic [6:0]  e;
    logic [11:0] m12;
    logic        rnd;

    always_comb begin
        a_nan = (&a[14:10]) && (|a[9:0]);
        b_nan = (&b[14:10]) && (|b[9:0]);
        a_inf = (&a[14:10]) && !(|a[9:0]);
        b_inf = (&b[14:10]) && !(|b[9:0]);

        // Order by magnitude so the difference is never negative.
        big = (b[14:0] > a[14:0]) ? b : a;
        sml = (b[14:0] > a[14:0]) ? a : b;

        // Subnormals share exponent 1 with a zero hidden bit.
        eb = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
        es = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
        d  = eb - es;

        // Three extra bits: guard, round, sticky.
        xb   = {big[14:10] != 5'd0, big[9:0], 3'b000};
        xs   = {sml[14:10] != 5'd0, sml[9:0], 3'b000};
        mask = (14'd1 << d) - 14'd1;
        al   = (xs >> d) | {13'd0, |(xs & mask)};

        s15 = (big[15] == sml[15]) ? ({1'b0, xb} + {1'b0, al})
                                   : ({1'b0, xb} - {1'b0, al});

        e = {2'b00, eb};
        if (s15[14]) begin
            s = s15[14:1] | {13'd0, s15[0]};
            e = e + 7'd1;
        end else begin
            s = s15[13:0];
        end

        // Left-normalise, stopping at the subnormal exponent.
        for (int i = 0; i < 13; i++) begin
            if (!s[13] && (e > 7'd1)) begin
                s = s << 1;
                e = e - 7'd1;
            end
        end

        rnd = s[2] & (s[1] | s[0] | s[3]);
        m12 = {1'b0, s[13:3]} + {11'd0, rnd};
        if (m12[11]) begin
            m12 = m12 >> 1;
            e   = e + 7'd1;
        end

        if (e >= 7'd31) begin
            res = {big[15], 5'h1F, 10'd0};
        end else begin
            res = {big[15], (m12[10] ? e[4:0] : 5'd0), m12[9:0]};
        end

        // Exact cancellation gives +0 unless both operands were negative.
        if (s15 == 15'd0) begin
            res = {big[15] & sml[15], 15'd0};
        end

        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
            res = 16'h7E00;
        end else if (a_inf) begin
            res = a;
        end else if (b_inf) begin
            res = b;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sum <= HALF_POS_ZERO;
        end else begin
            sum <= res;
        end
    end

endmodule

// File: rtl/half_tree_v.sv
// rtl/half_tree_v.sv - masked, padded, pipelined LANES-to-1 half_add tree with sideband delay
// Ports: clk, rstn; in_valid/in_first/in_last/in_keep/in_data beat in;
//        tree_valid/tree_first/tree_last/tree_cnt/tree_sum out, $clog2(LANES) cycles later.
module half_tree_v
    import half_pkg::*;
#(
    parameter int LANES = 8,
    parameter int CW    = $clog2(LANES + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [LANES-1:0] in_keep,
    input  half_t            in_data [LANES],
    output logic             tree_valid,
    output logic             tree_first,
    output logic             tree_last,
    output logic [CW-1:0]    tree_cnt,
    output half_t            tree_sum
);

    localparam int LEVELS = $clog2(LANES);
    localparam int P      = 1 << LEVELS;

    // Heap layout: node[1] is the root, node[P..2P-1] are the leaves.
    half_t node [1:2*P-1];

    for (genvar j = 0; j < P; j++) begin : g_leaf
        if (j < LANES) begin : g_lane
            assign node[P+j] = in_keep[j] ? in_data[j] : HALF_POS_ZERO;
        end else begin : g_pad
            assign node[P+j] = HALF_POS_ZERO;
        end
    end

    for (genvar i = 1; i < P; i++) begin : g_add
        half_add u_add (
            .clk  (clk),
            .rstn (rstn),
            .a    (node[2*i]),
            .b    (node[2*i+1]),
            .sum  (node[i])
        );
    end

    assign tree_sum = node[1];

    logic [CW-1:0]   pop;
    logic [CW+2:0]   side_d, side_q;

    assign pop    = CW'(popcount(POP_MAX'(in_keep)));
    assign side_d = {in_valid, in_first, in_last, pop};

    delay #(
        .WIDTH (CW + 3),
        .DEPTH (LEVELS)
    ) u_side (
        .clk  (clk),
        .rstn (rstn),
        .d    (side_d),
        .q    (side_q)
    );

    assign {tree_valid, tree_first, tree_last, tree_cnt} = side_q;

endmodule

// File: rtl/half_sum_acc_v.sv
// rtl/half_sum_acc_v.sv - streaming binary16 vector summer: tree per beat, accumulator across beats
// Ports: clk, rstn (async, active-low); in_valid/in_last/in_keep/in_data beat in (no backpressure);
//        out_valid one-cycle pulse per vector, out_sum binary16 sum, out_count saturating kept count.
module half_sum_acc_v
    import half_pkg::*;
#(
    parameter int LANES = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [LANES-1:0] in_keep,
    input  half_t            in_data [LANES],
    output logic             out_valid,
    output half_t            out_sum,
    output logic [CNT_W-1:0] out_count
);

    localparam int CW = $clog2(LANES + 1);

    acc_state_t state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else if (in_valid) begin
            state <= in_last ? IDLE : ACCUM;
        end
    end

    logic          tree_valid, tree_first, tree_last;
    logic [CW-1:0] tree_cnt;
    half_t         tree_sum;

    half_tree_v #(
        .LANES (LANES),
        .CW    (CW)
    ) u_tree (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_first   (in_valid && (state == IDLE)),
        .in_last    (in_valid && in_last),
        .in_keep    (in_keep),
        .in_data    (in_data),
        .tree_valid (tree_valid),
        .tree_first (tree_first),
        .tree_last  (tree_last),
        .tree_cnt   (tree_cnt),
        .tree_sum   (tree_sum)
    );

    // A first beat restarts from +0; idle cycles add +0 so acc holds.
    half_t acc, acc_a, acc_b;

    assign acc_a = tree_valid ? tree_sum : HALF_POS_ZERO;
    assign acc_b = (tree_valid && tree_first) ? HALF_POS_ZERO : acc;

    half_add u_acc (
        .clk  (clk),
        .rstn (rstn),
        .a    (acc_a),
        .b    (acc_b),
        .sum  (acc)
    );

    logic [CNT_W-1:0] cnt, cnt_base, cnt_next, sum_cnt_q;
    logic [CNT_W:0]   cnt_ext;
    half_t            sum_q;

    always_comb begin
        cnt_base = tree_first ? '0 : cnt;
        cnt_ext  = {1'b0, cnt_base} + (CNT_W+1)'(tree_cnt);
        cnt_next = cnt_ext[CNT_W] ? '1 : cnt_ext[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt       <= '0;
            out_valid <= 1'b0;
            sum_q     <= HALF_POS_ZERO;
            sum_cnt_q <= '0;
        end else begin
            out_valid <= tree_valid && tree_last;
            if (tree_valid) begin
                cnt <= cnt_next;
            end
            if (out_valid) begin
                sum_q     <= acc;
                sum_cnt_q <= cnt;
            end
        end
    end

    // acc/cnt move on with the next vector, so the completed result is held separately.
    assign out_sum   = out_valid ? acc : sum_q;
    assign out_count = out_valid ? cnt : sum_cnt_q;

endmodule

// File: tb/tb_half_sum_acc_v.sv
// tb/tb_half_sum_acc_v.sv - scoreboard bench for half_sum_acc_v
module tb_half_sum_acc_v;
    import half_pkg::*;

    localparam int LANES = 8;
    localparam int CNT_W = 16;
    localparam int LAT   = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_last = 1'b0;
    logic [LANES-1:0] in_keep = '0;
    half_t            in_data [LANES];
    logic             out_valid;
    half_t            out_sum;
    logic [CNT_W-1:0] out_count;

    half_sum_acc_v #(
        .LANES (LANES),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_keep   (in_keep),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    half_t       exp_sum_q [$];
    logic [15:0] exp_cnt_q [$];
    int          exp_cyc_q [$];
    string       tag = "reset";

    task automatic beat(input half_t lo, input half_t hi, input logic [7:0] keep, input logic last);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_last  = last;
        in_keep  = keep;
        for (int i = 0; i < LANES; i++) in_data[i] = (i < 4) ? lo : hi;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_last  = 1'b0;
        end
    endtask

    task automatic expect_out(input half_t s, input logic [15:0] c);
        exp_sum_q.push_back(s);
        exp_cnt_q.push_back(c);
        exp_cyc_q.push_back(cyc);
    endtask

    initial begin
        half_t mixed [LANES];
        half_t       es;
        logic [15:0] ec;
        int          ecyc;

        mixed = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                  16'h4500, 16'h4600, 16'h4700, 16'h4800};
        for (int i = 0; i < LANES; i++) in_data[i] = HALF_POS_ZERO;

        fork
            forever begin
                @(negedge clk);
                if (!rstn) begin
                    checks++;
                    assert (out_valid === 1'b0) else begin errors++; $error("FAIL rst_valid observed=%b expected=0", out_valid); end
                    checks++;
                    assert (out_sum === 16'h0000) else begin errors++; $error("FAIL rst_sum observed=%h expected=0000", out_sum); end
                    checks++;
                    assert (out_count === 16'd0) else begin errors++; $error("FAIL rst_count observed=%0d expected=0", out_count); end
                end else if (out_valid !== 1'b0) begin
                    checks++;
                    assert (exp_sum_q.size() > 0) else begin errors++; $error("FAIL %s spurious_pulse observed out_valid=%b expected no pulse", tag, out_valid); end
                    if (exp_sum_q.size() > 0) begin
                        es   = exp_sum_q.pop_front();
                        ec   = exp_cnt_q.pop_front();
                        ecyc = exp_cyc_q.pop_front();
                        checks++;
                        assert (out_sum === es) else begin errors++; $error("FAIL %s sum observed=%h expected=%h", tag, out_sum, es); end
                        checks++;
                        assert (out_count === ec) else begin errors++; $error("FAIL %s count observed=%0d expected=%0d", tag, out_count, ec); end
                        checks++;
                        assert (cyc - ecyc == LAT) else begin errors++; $error("FAIL %s latency observed=%0d expected=%0d", tag, cyc - ecyc, LAT); end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);

        tag = "single";
        beat(HALF_ONE, HALF_ONE, 8'hFF, 1'b1);
        expect_out(16'h4800, 16'd8);
        idle(6);

        tag = "two_beat";
        beat(HALF_ONE, HALF_ONE, 8'hFF, 1'b0);
        beat(HALF_ONE, HALF_ONE, 8'hFF, 1'b1);
        expect_out(16'h4C00, 16'd16);
        idle(6);

        tag = "masked_nan";
        beat(16'h4000, 16'h7E00, 8'h0F, 1'b1);
        expect_out(16'h4800, 16'd4);
        idle(6);

        tag = "back_to_back";
        beat(HALF_ONE, HALF_ONE, 8'hFF, 1'b1);
        expect_out(16'h4800, 16'd8);
        beat(16'h3800, 16'h3800, 8'hFF, 1'b1);
        expect_out(16'h4400, 16'd8);
        idle(6);

        tag = "gaps";
        beat(HALF_ONE, HALF_ONE, 8'hFF, 1'b0);
        idle(3);
        beat(HALF_ONE, HALF_ONE, 8'hFF, 1'b1);
        expect_out(16'h4C00, 16'd16);
        idle(6);

        tag = "mixed";
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_keep  = 8'hFF;
        for (int i = 0; i < LANES; i++) in_data[i] = mixed[i];
        expect_out(16'h5080, 16'd8);
        idle(6);

        tag = "abort";
        beat(HALF_ONE, HALF_ONE, 8'hFF, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        rstn     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        idle(2);
        beat(16'h4000, 16'h4000, 8'hFF, 1'b1);
        expect_out(16'h4C00, 16'd8);
        idle(10);

        tag = "final";
        checks++;
        assert (exp_sum_q.size() == 0) else begin errors++; $error("FAIL missing_pulse observed pending=%0d expected=0", exp_sum_q.size()); end
        checks++;
        assert (out_sum === 16'h4C00) else begin errors++; $error("FAIL hold_sum observed=%h expected=4c00", out_sum); end
        checks++;
        assert (out_count === 16'd8) else begin errors++; $error("FAIL hold_count observed=%0d expected=8", out_count); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/half_sum_acc_v.md
Name: half_sum_acc_v

Overview:
- Streaming half-precision (binary16) vector summer, generalised to vectors of arbitrary length.
- Each beat presents LANES elements with a per-lane keep mask.
- A pipelined adder tree reduces each beat to one partial sum. A feedback accumulator adds the partial sums of all beats up to and including the beat flagged in_last.
- Sits in the datapath wherever dot-product and reduction results exceed one beat of lanes.

Parameters:
- LANES, 8, elements per beat; any value >= 1; tree depth LEVELS = $clog2(LANES), and LANES=1 gives LEVELS=0.
- CNT_W, 16, width of the kept-element counter.

Ports:
- clk  input  1  clock.
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  beat valid; no backpressure, so every valid beat is accepted.
- in_last  input  1  final beat of the current vector; qualified by in_valid.
- in_keep  input  LANES  per-lane enable; a lane with keep=0 contributes +0 (16'h0000).
- in_data  input  [15:0] x LANES  unpacked array of binary16 elements.
- out_valid  output  1  one-cycle pulse, one per completed vector.
- out_sum  output  16  binary16 sum of all kept elements of the vector.
- out_count  output  CNT_W  number of kept elements in the vector; saturates at all-ones.

Behaviour:
- Interface: one clock (clk); reset rstn is asynchronous, active-low. All flops clear on rstn=0.
- Reset values: out_valid=0, out_sum=16'h0000, out_count=0, state=IDLE, all pipeline valid/last/first flags=0.
- Input FSM, states IDLE and ACCUM:
  - IDLE: valid beat with in_last=0 goes to ACCUM; valid beat with in_last=1 stays IDLE (single-beat vector).
  - ACCUM: valid beat with in_last=1 goes to IDLE; otherwise stays.
  - A beat is tagged first when it arrives in IDLE.
- Masking: lanes with keep=0 are replaced by 16'h0000 before the tree.
- Padding: lanes LANES..2**LEVELS-1 are tied to 16'h0000.
- Tree:
  - LEVELS stages of half_add, one register per stage, always enabled.
  - The valid, first, last and popcount sideband travels alongside through a delay of LEVELS cycles.
- Accumulator: one half_add (latency 1) whose output register is the accumulator acc. Inputs per cycle:
  - tree valid & first: a = tree_out, b = +0.
  - tree valid & !first: a = tree_out, b = acc.
  - tree not valid: a = +0, b = acc, so acc holds. Caveat: -0 normalises to +0.
- Gaps: idle cycles between beats of one vector are permitted and do not corrupt acc.
- Count: cnt register follows the same first/accumulate rule using popcount(in_keep), saturating at 2**CNT_W-1.
- Latency: out_valid pulses LEVELS+1 cycles after the in_last beat. out_sum = acc, out_count = cnt at that cycle. out_sum/out_count hold until the next out_valid.
- Throughput: one beat per cycle. Back-to-back single-beat vectors yield out_valid on consecutive cycles.
- Reset mid-vector: the partial vector and all in-flight beats are discarded; no out_valid is produced for them. The first valid beat after rstn deasserts starts a new vector.
- Arithmetic (NaN, Inf, rounding, subnormals) is exactly that of half_add. No additional checking.

Decomposition:
- Package half_pkg:
  - typedef half_t = logic [15:0].
  - constants HALF_POS_ZERO=16'h0000 and HALF_ONE=16'h3C00.
  - function popcount.
- Sub-module half_tree_v: masked, padded, pipelined LANES-to-1 tree of half_add, including the sideband delay.
- Top half_sum_acc_v: contains the FSM, the accumulator half_add and the counter.
- Reuses the existing half_add and delay modules.

Test Plan (LANES=8, latency 4):
- Single beat, all 3C00 (1.0), keep=FF, last -> 4 cycles later out_valid=1, out_sum=4800 (8.0), out_count=8.
- Two consecutive beats all 3C00, keep=FF, second last -> out_sum=4C00 (16.0), out_count=16, one pulse only.
- One beat 4000 (2.0) x8, keep=0F, last -> out_sum=4800, out_count=4; masked lanes ignored even if NaN (7E00).
- Back-to-back: beat 3C00x8 last, next cycle beat 3800 (0.5) x8 last -> out_sum 4800 then 4400 on consecutive cycles.
- Beat 3C00x8, 3 idle cycles, beat 3C00x8 last -> out_sum=4C00, out_count=16.
- Beat 3C00x8 (not last), rstn pulsed low, then beat 4000x8 last -> no pulse for the aborted vector; out_sum=4C00, out_count=8; out_valid=0 throughout reset.
